// File: rtl/register_dump_unit.sv
// Dumps the register file through the debug read port as little-endian bytes to the UART TX.
// Define REG_DUMP_CHECKSUM_EN to append one XOR checksum byte after the register bytes.
module register_dump_unit #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_BYTE        = 8,
  parameter int N_REGS         = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic [NB_REG_ADDRESS-1:0] o_direc_de_lectura_de_debug,
  input  logic [NB_DATA-1:0]        i_dato_a_debug,
  output logic [NB_BYTE-1:0]        o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int N_BYTES     = NB_DATA / NB_BYTE;
  localparam int NB_BYTE_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_REG_ADDRESS-1:0] LAST_REG  = NB_REG_ADDRESS'(N_REGS - 1);
  localparam logic [NB_BYTE_IDX-1:0]    LAST_BYTE = NB_BYTE_IDX'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    LATCH,
    SEND,
    WAIT_TX,
    FINISH
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    CHK_SEND,
    CHK_WAIT
`endif
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [NB_REG_ADDRESS-1:0] reg_idx_q;
  logic [NB_BYTE_IDX-1:0]    byte_idx_q;
  logic [NB_DATA-1:0]        word_q;
  logic [NB_BYTE-1:0]        cur_byte;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]        checksum_q;
`endif

  assign cur_byte = word_q[byte_idx_q*NB_BYTE +: NB_BYTE];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start) state_d = SET_ADDR;
      SET_ADDR: state_d = LATCH;
      LATCH:    state_d = SEND;
      SEND:     state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            state_d = SEND;
          end else if (reg_idx_q != LAST_REG) begin
            state_d = SET_ADDR;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = CHK_SEND;
`else
            state_d = FINISH;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CHK_SEND: state_d = CHK_WAIT;
      CHK_WAIT: if (i_tx_done) state_d = FINISH;
`endif
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decode from the current state; the byte stays put until the handshake completes
  always_comb begin
    o_tx_data  = '0;
    o_tx_start = 1'b0;
    o_busy     = (state_q != IDLE) && (state_q != FINISH);
    o_done     = (state_q == FINISH);
    case (state_q)
      SEND: begin
        o_tx_data  = cur_byte;
        o_tx_start = 1'b1;
      end
      WAIT_TX:  o_tx_data = cur_byte;
`ifdef REG_DUMP_CHECKSUM_EN
      CHK_SEND: begin
        o_tx_data  = checksum_q;
        o_tx_start = 1'b1;
      end
      CHK_WAIT: o_tx_data = checksum_q;
`endif
      default: ;
    endcase
  end

  assign o_direc_de_lectura_de_debug = reg_idx_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (i_start) reg_idx_q <= '0;
        LATCH: begin
          word_q     <= i_dato_a_debug;
          byte_idx_q <= '0;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + NB_BYTE_IDX'(1);
            end else if (reg_idx_q != LAST_REG) begin
              reg_idx_q <= reg_idx_q + NB_REG_ADDRESS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  // Every register byte is folded in on the cycle it is offered to the UART
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      checksum_q <= '0;
    end else if (state_q == IDLE && i_start) begin
      checksum_q <= '0;
    end else if (state_q == SEND) begin
      checksum_q <= checksum_q ^ cur_byte;
    end
  end
`endif

endmodule

// File: tb/tb_register_dump_unit.sv
// Self-checking bench for register_dump_unit: a UART TX responder collects bytes and
// compares them against a byte stream computed from the bench's own register file image.
module tb_register_dump_unit;

  localparam int NB_DATA        = 32;
  localparam int NB_REG_ADDRESS = 5;
  localparam int NB_BYTE        = 8;
  localparam int N_REGS         = 32;
  localparam int BUDGET         = 3000;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      start;
  logic [NB_REG_ADDRESS-1:0] readAddr;
  logic [NB_DATA-1:0]        readData;
  logic [NB_BYTE-1:0]        txData;
  logic                      txStart;
  logic                      txDone;
  logic                      busy;
  logic                      done;

  int checks = 0;
  int errors = 0;
  int txDelay = 5;
  int countdown = 0;
  bit respDone = 1'b0;
  int doneCount = 0;
  int txStartCount = 0;
  logic [7:0]  rxQ[$];
  logic [7:0]  expQ[$];
  logic [31:0] regFile [N_REGS];

  register_dump_unit #(
    .NB_DATA(NB_DATA), .NB_REG_ADDRESS(NB_REG_ADDRESS), .NB_BYTE(NB_BYTE), .N_REGS(N_REGS)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_start(start),
    .o_direc_de_lectura_de_debug(readAddr),
    .i_dato_a_debug(readData),
    .o_tx_data(txData),
    .o_tx_start(txStart),
    .i_tx_done(txDone),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clock = ~clock;

  assign readData = regFile[readAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected stream: each register low byte first, ascending index, optional XOR trailer
  function automatic void buildExpected();
    logic [7:0] x;
    x = 8'h00;
    expQ.delete();
    for (int r = 0; r < N_REGS; r++) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] v;
        v = 8'((regFile[r] >> (8 * b)) & 32'hFF);
        expQ.push_back(v);
        x = x ^ v;
      end
    end
    if (CHK_EN) expQ.push_back(x);
  endfunction

  // UART TX model: capture each requested byte and answer txDelay cycles later
  initial begin
    txDone = 1'b0;
    forever begin
      @(negedge clock);
      if (respDone) begin
        txDone   = 1'b0;
        respDone = 1'b0;
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          txDone   = 1'b1;
          respDone = 1'b1;
        end
      end
      if (txStart) begin
        rxQ.push_back(txData);
        txStartCount++;
        countdown = txDelay;
      end
      if (done) doneCount++;
    end
  end

  // Starts a dump and checks the start-up latency; optionally injects stray txDone pulses
  task automatic applyStimulus(input bit spurious);
    @(negedge clock);
    checkOutput("busyBeforeStart", busy, 0);
    start  = 1'b1;
    txDone = spurious;
    @(negedge clock);
    start  = 1'b0;
    txDone = spurious;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("addrSetAddr", readAddr, 0);
    checkOutput("txStartSetAddr", txStart, 0);
    @(negedge clock);
    txDone = spurious;
    checkOutput("addrLatch", readAddr, 0);
    checkOutput("txStartLatch", txStart, 0);
    @(negedge clock);
    txDone = spurious;
    checkOutput("txStartLatency", txStart, 1);
    checkOutput("firstByte", txData, expQ[0]);
    @(negedge clock);
    txDone = 1'b0;
    checkOutput("txStartWait", txStart, 0);
  endtask

  task automatic waitBytes(input int n);
    int c;
    c = 0;
    while (rxQ.size() < n && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    checkOutput($sformatf("bytesReached%0d", n), rxQ.size() >= n, 1);
  endtask

  task automatic waitDone(input int target);
    int c;
    c = 0;
    while (doneCount < target && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    checkOutput("doneInTime", c < BUDGET, 1);
    repeat (10) @(negedge clock);
    checkOutput("doneCount", doneCount, target);
    checkOutput("busyAfterDone", busy, 0);
  endtask

  task automatic compareStream();
    checkOutput("byteCount", rxQ.size(), expQ.size());
    for (int i = 0; i < rxQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("byte%0d", i), rxQ[i], expQ[i]);
    end
  endtask

  task automatic freshDump();
    buildExpected();
    rxQ.delete();
    doneCount = 0;
  endtask

  initial begin
    int startsBefore;
    reset = 1'b1;
    start = 1'b0;
    for (int r = 0; r < N_REGS; r++) regFile[r] = 32'h0;
    repeat (3) @(negedge clock);
    checkOutput("rstTxStart", txStart, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstAddr", readAddr, 0);
    checkOutput("rstTxData", txData, 0);
    reset = 1'b0;

    // Directed register image with a fixed 5-cycle UART
    for (int r = 0; r < N_REGS; r++) regFile[r] = r;
    regFile[1] = 32'h11223344;
    txDelay = 5;
    freshDump();
    applyStimulus(1'b0);
    waitDone(1);
    compareStream();
    if (rxQ.size() >= 4 * N_REGS) begin
      checkOutput("r1b0", rxQ[4], 8'h44);
      checkOutput("r1b1", rxQ[5], 8'h33);
      checkOutput("r1b2", rxQ[6], 8'h22);
      checkOutput("r1b3", rxQ[7], 8'h11);
      checkOutput("lastB0", rxQ[4*N_REGS-4], 8'h1F);
      checkOutput("lastB1", rxQ[4*N_REGS-3], 8'h00);
      checkOutput("lastB2", rxQ[4*N_REGS-2], 8'h00);
      checkOutput("lastB3", rxQ[4*N_REGS-1], 8'h00);
    end

    // Stray handshakes at start-up plus a second start request mid-dump
    txDelay = 3;
    freshDump();
    applyStimulus(1'b1);
    waitBytes(10);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone(1);
    compareStream();

    // Reset while waiting on register 7, then a clean restart
    for (int r = 0; r < N_REGS; r++) regFile[r] = $urandom;
    txDelay = 5;
    freshDump();
    applyStimulus(1'b0);
    waitBytes(29);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abortTxStart", txStart, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortAddr", readAddr, 0);
    checkOutput("abortTxData", txData, 0);
    reset = 1'b0;
    startsBefore = txStartCount;
    repeat (20) @(negedge clock);
    checkOutput("noTxAfterReset", txStartCount, startsBefore);
    checkOutput("noDoneAfterReset", doneCount, 0);
    rxQ.delete();
    applyStimulus(1'b0);
    waitDone(1);
    compareStream();

    // Random images and UART latencies; register 0 is overwritten after it was latched
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < N_REGS; r++) regFile[r] = $urandom;
      txDelay = $urandom_range(1, 8);
      freshDump();
      applyStimulus(1'b0);
      regFile[0] = ~regFile[0];
      waitDone(1);
      compareStream();
    end

    if (CHK_EN) begin
      for (int r = 0; r < N_REGS; r++) regFile[r] = 32'hA5A5A5A5;
      regFile[0] = 32'h0;
      txDelay = 2;
      freshDump();
      applyStimulus(1'b0);
      waitDone(1);
      compareStream();
      checkOutput("chkCountA5", rxQ.size(), 4 * N_REGS + 1);
      if (rxQ.size() > 4 * N_REGS) checkOutput("chkA5", rxQ[4*N_REGS], 8'h00);

      for (int r = 0; r < N_REGS; r++) regFile[r] = 32'h0;
      regFile[1] = 32'h000000FF;
      freshDump();
      applyStimulus(1'b0);
      waitDone(1);
      compareStream();
      if (rxQ.size() > 4 * N_REGS) checkOutput("chkFF", rxQ[4*N_REGS], 8'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
